// File: rtl/frogger_cmp_pkg.sv
// Shared types and constants for the frogger compare arbiter.
// Default operand width matches the screen x-coordinate width.
package frogger_cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 10;

endpackage

// File: rtl/cmp_stage.sv
// Registered unsigned WIDTH-bit "A greater than B" stage.
// Loads a new result only when enabled; holds it otherwise.
module cmp_stage
   import frogger_cmp_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             gt
);

   logic gt_q;
   logic gt_d;

   always_comb begin
      gt_d = gt_q;
      if (en) begin
         gt_d = (a > b);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gt_q <= 1'b0;
      end else begin
         gt_q <= gt_d;
      end
   end

   assign gt = gt_q;

endmodule

// File: rtl/compare_arbiter.sv
// Round-robin arbiter sharing one registered A>B comparator among NUM_REQ
// requesters; captures the winner's operands and returns a tagged result.
module compare_arbiter
   import frogger_cmp_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] a_in,
   input  logic [NUM_REQ*WIDTH-1:0] b_in,
   output logic [NUM_REQ-1:0]       gnt,
   output logic                     busy,
   output logic                     done,
   output logic [ID_W-1:0]          done_id,
   output logic                     a_gt_b
);

   localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
   localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

   state_t             state_q, state_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [WIDTH-1:0]   op_a_q, op_a_d;
   logic [WIDTH-1:0]   op_b_q, op_b_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic               done_q, done_d;
   logic [ID_W-1:0]    done_id_q, done_id_d;
   logic               a_gt_b_q, a_gt_b_d;

   logic               win_found;
   logic [ID_W-1:0]    win_id;
   logic [ID_W:0]      scan_sum;
   logic [ID_W-1:0]    scan_idx;
   logic               stage_gt;

   // Scan from ptr upward with an explicit wrap so non-power-of-two counts work.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      scan_sum  = '0;
      scan_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_sum = {1'b0, ptr_q} + (ID_W+1)'(k);
         if (scan_sum >= NUM_REQ_W) begin
            scan_sum = scan_sum - NUM_REQ_W;
         end
         scan_idx = scan_sum[ID_W-1:0];
         if (!win_found && req[scan_idx]) begin
            win_found = 1'b1;
            win_id    = scan_idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      id_d      = id_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      gnt_d     = '0;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      a_gt_b_d  = a_gt_b_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               op_a_d  = a_in[win_id*WIDTH +: WIDTH];
               op_b_d  = b_in[win_id*WIDTH +: WIDTH];
               id_d    = win_id;
               ptr_d   = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
               gnt_d   = NUM_REQ'(1) << win_id;
               state_d = CMP;
            end
         end
         CMP: begin
            state_d = RESP;
         end
         RESP: begin
            done_d    = 1'b1;
            done_id_d = id_q;
            a_gt_b_d  = stage_gt;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         id_q      <= '0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         gnt_q     <= '0;
         done_q    <= 1'b0;
         done_id_q <= '0;
         a_gt_b_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         id_q      <= id_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         a_gt_b_q  <= a_gt_b_d;
      end
   end

   cmp_stage #(
      .WIDTH(WIDTH)
   ) u_cmp_stage (
      .clk  (clk),
      .reset(reset),
      .en   (state_q == CMP),
      .a    (op_a_q),
      .b    (op_b_q),
      .gt   (stage_gt)
   );

   assign gnt     = gnt_q;
   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign done_id = done_id_q;
   assign a_gt_b  = a_gt_b_q;

endmodule

// File: tb/tb_compare_arbiter.sv
// Self-checking bench for compare_arbiter: table vectors, hand sequences and
// randomized traffic against a round-robin reference model.
module tb_compare_arbiter;

   localparam int NR = 4;
   localparam int W  = 10;
   localparam int IW = 2;

   logic            clk;
   logic            reset;
   logic [NR-1:0]   req;
   logic [NR*W-1:0] a_in;
   logic [NR*W-1:0] b_in;
   logic [NR-1:0]   gnt;
   logic            busy;
   logic            done;
   logic [IW-1:0]   done_id;
   logic            a_gt_b;

   logic [W-1:0] a_arr [NR];
   logic [W-1:0] b_arr [NR];

   int n_checks;
   int n_pass;
   int m_ptr;
   bit last_gt;

   compare_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .a_in   (a_in),
      .b_in   (b_in),
      .gnt    (gnt),
      .busy   (busy),
      .done   (done),
      .done_id(done_id),
      .a_gt_b (a_gt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      a_in = '0;
      b_in = '0;
      for (int i = 0; i < NR; i++) begin
         a_in[i*W +: W] = a_arr[i];
         b_in[i*W +: W] = b_arr[i];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arbitration: first requester at or after the pointer, modulo NR.
   function automatic int model_winner(input logic [NR-1:0] mask);
      int i;
      for (int k = 0; k < NR; k++) begin
         i = (m_ptr + k) % NR;
         if (mask[i]) return i;
      end
      return -1;
   endfunction

   // Serve every requester in mask; each drops its req after seeing gnt.
   task automatic serve(input logic [NR-1:0] mask, input bit perturb, output bit got_gt);
      logic [NR-1:0] pend;
      int w;
      bit exp_gt;
      pend   = mask;
      got_gt = 1'b0;
      req    = pend;
      while (pend != '0) begin
         w = model_winner(pend);
         tick();
         check("gnt", int'(gnt), 1 << w);
         check("busy_cmp", int'(busy), 1);
         check("hold_gt", int'(a_gt_b), int'(last_gt));
         exp_gt = (int'(a_arr[w]) > int'(b_arr[w]));
         m_ptr  = (w + 1) % NR;
         pend[w] = 1'b0;
         req     = pend;
         if (perturb) begin
            a_arr[w] = exp_gt ? '0 : '1;
            b_arr[w] = exp_gt ? '1 : '0;
         end
         tick();
         check("gnt_pulse", int'(gnt), 0);
         check("done_early", int'(done), 0);
         tick();
         check("done", int'(done), 1);
         check("done_id", int'(done_id), w);
         check("a_gt_b", int'(a_gt_b), int'(exp_gt));
         check("busy_idle", int'(busy), 0);
         got_gt  = a_gt_b;
         last_gt = exp_gt;
         $display("txn id=%0d a=%0d b=%0d gt=%0d", w, int'(a_arr[w]), int'(b_arr[w]), int'(a_gt_b));
      end
      tick();
      check("done_pulse", int'(done), 0);
      check("idle_gnt", int'(gnt), 0);
   endtask

   typedef struct {
      int       who;
      logic [W-1:0] a;
      logic [W-1:0] b;
      bit       exp_gt;
   } vec_t;

   initial begin
      vec_t vecs [8];
      bit   g;
      logic [NR-1:0] m;

      n_checks = 0;
      n_pass   = 0;
      m_ptr    = 0;
      last_gt  = 1'b0;
      req      = '0;
      for (int i = 0; i < NR; i++) begin
         a_arr[i] = '0;
         b_arr[i] = '0;
      end

      vecs[0] = '{0, 10'd1023, 10'd0,    1'b1};
      vecs[1] = '{0, 10'd0,    10'd1023, 1'b0};
      vecs[2] = '{1, 10'd256,  10'd256,  1'b0};
      vecs[3] = '{2, 10'd1023, 10'd1023, 1'b0};
      vecs[4] = '{3, 10'd1,    10'd0,    1'b1};
      vecs[5] = '{3, 10'd0,    10'd1,    1'b0};
      vecs[6] = '{2, 10'd512,  10'd511,  1'b1};
      vecs[7] = '{1, 10'd511,  10'd512,  1'b0};

      // Reset state
      reset = 1'b0;
      repeat (3) tick();
      check("rst_gnt", int'(gnt), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_done_id", int'(done_id), 0);
      check("rst_gt", int'(a_gt_b), 0);
      reset = 1'b1;
      tick();

      // Simultaneous requests from reset: order 0,1,2,3
      a_arr[0] = 10'd300; b_arr[0] = 10'd100;
      a_arr[1] = 10'd100; b_arr[1] = 10'd300;
      a_arr[2] = 10'd700; b_arr[2] = 10'd699;
      a_arr[3] = 10'd5;   b_arr[3] = 10'd5;
      serve(4'b1111, 1'b0, g);

      // Table-driven single-requester vectors
      for (int i = 0; i < 8; i++) begin
         a_arr[vecs[i].who] = vecs[i].a;
         b_arr[vecs[i].who] = vecs[i].b;
         serve(NR'(1) << vecs[i].who, 1'b0, g);
         check("vec_gt", int'(g), int'(vecs[i].exp_gt));
      end

      // Fairness: after serving 2, req 0101 grants 0 before 2
      a_arr[2] = 10'd3; b_arr[2] = 10'd9;
      serve(4'b0100, 1'b0, g);
      a_arr[0] = 10'd9; b_arr[0] = 10'd3;
      serve(4'b0101, 1'b0, g);

      // Operand stability: A2 changes 500 -> 0 after gnt
      a_arr[2] = 10'd500; b_arr[2] = 10'd400;
      serve(4'b0100, 1'b1, g);
      check("stable_gt", int'(g), 1);

      // Reset during CMP aborts the compare
      a_arr[1] = 10'd900; b_arr[1] = 10'd1;
      req = 4'b0010;
      tick();
      check("pre_rst_gnt", int'(gnt), 2);
      #1 reset = 1'b0;
      req = '0;
      #1;
      check("mid_rst_gnt", int'(gnt), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_done", int'(done), 0);
      check("mid_rst_id", int'(done_id), 0);
      check("mid_rst_gt", int'(a_gt_b), 0);
      tick();
      reset = 1'b1;
      m_ptr = 0;
      last_gt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("no_done_after_rst", int'(done), 0);
      end
      a_arr[3] = 10'd2; b_arr[3] = 10'd1;
      serve(4'b1000, 1'b0, g);

      // Randomized traffic against the model
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < NR; i++) begin
            a_arr[i] = W'($urandom_range(0, 1023));
            b_arr[i] = ($urandom_range(0, 3) == 0) ? a_arr[i] : W'($urandom_range(0, 1023));
         end
         m = NR'($urandom_range(0, 15));
         serve(m, ($urandom_range(0, 3) == 0), g);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
